serial_adder_sequencer: RTL

//   Sequences one shared single-bit full adder (external, combinational) to add two

---
 rtl/serial_adder_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder sequencer: drives one shared external full adder,
// LSB first, one operand bit per clock, with valid/ready on both sides.
module serial_adder_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [WIDTH:0]   sum_cat;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, step, last;

  // New sum bit enters at the MSB; after WIDTH steps the LSB lands in bit 0.
  assign sum_cat = {fa_sum, sum_sr};
  assign sum     = sum_sr;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and handshake / adder-drive outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = carry;
        step   = 1'b1;
        last   = (cnt == LAST);
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Handoff returns to IDLE; a coincident in_valid waits a cycle.
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand shifters, running carry, bit counter and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_cat[WIDTH:1];
      carry  <= fa_cout;
      // Counter parks at the last index so it never exceeds WIDTH-1.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        cout <= fa_cout;
        // Carry into the MSB is fa_cin of the final bit.
        ovf  <= fa_cin ^ fa_cout;
      end
    end
  end

endmodule
